alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
- Parametrised successor to the single-cycle ALU + ALU control pair: one unit that decodes ALUOp/Funct3/Funct7 internally and executes the RV base integer ops plus the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the EX stage behind a valid/ready handshake.
- Base ops have a registered 1-cycle latency. Mul/div run iteratively for XLEN cycles while Busy_o stalls the pipeline.

Parameters:
- XLEN, 32: operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(XLEN): shift-amount width, derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Valid_i  in  1  operation request.
- Ready_o  out  1  unit can accept; the op is accepted on an edge where Valid_i && Ready_o.
- OperandA_i  in  XLEN  rs1 / dividend / multiplicand.
- OperandB_i  in  XLEN  rs2 or imm / divisor / multiplier.
- Funct7_i  in  7  instruction funct7.
- Funct3_i  in  3  instruction funct3.
- ALUOp_i  in  2  00 = ADD (ld/st address), 01 = SUB (branch compare), 10 = R-type decode, 11 = I-type decode.
- Flush_i  in  1  abort any in-flight op (branch mispredict).
- Valid_o  out  1  one-cycle pulse; Result_o is valid in that cycle.
- Result_o  out  XLEN  result register; holds its value until the next completion.
- Busy_o  out  1  mul/div iteration in progress (= !Ready_o).

Behaviour:
- Reset (rst_i high at an edge): state = IDLE, Valid_o = 0, Result_o = 0, Ready_o = 1, Busy_o = 0, counter = 0. Reset mid-iteration abandons the op; no Valid_o is produced.
- Decode:
  - R-type, Funct7 = 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by Funct3.
  - R-type, Funct7 = 0100000: SUB for Funct3 = 000, SRA for Funct3 = 101.
  - R-type, Funct7 = 0000001: M-ext op by Funct3.
  - I-type: Funct3 selects the op; SUB is never selected; Funct7[5] selects SRAI vs SRLI for Funct3 = 101.
  - Any other Funct7 in R-type: result 0, latency 1.
- Shifts use OperandB_i[SHAMT_W-1:0]. SLT/SLTU produce 0 or 1, zero-extended.
- State machine: IDLE, MUL, DIV.
  - Ready_o = (state == IDLE).
  - IDLE, base op accepted at edge k: result registered, Valid_o = 1 during cycle k+1, stay IDLE. Back-to-back base ops are accepted every cycle.
  - IDLE, MUL* accepted: latch |A| and |B| per signedness (MULH: both signed; MULHSU: A signed, B unsigned; MULHU and MUL: unsigned), go MUL, counter = 0.
  - MUL: one shift-add step per cycle into a 2*XLEN accumulator. After step XLEN-1, apply sign correction and select the low half (MUL) or high half (MULH*). Write Result_o and pulse Valid_o in cycle k+XLEN+1, return to IDLE.
  - IDLE, DIV* accepted with a normal case: latch magnitudes, go DIV. Restoring division, one quotient bit per cycle, XLEN cycles. Signed quotient is negated if operand signs differ; signed remainder takes the dividend's sign. Completion timing matches MUL.
  - Special cases complete in 1 cycle with no DIV state (Valid_o in cycle k+1):
    - Divide by zero: DIV/DIVU = all ones; REM/REMU = OperandA.
    - Signed overflow (A = most negative, B = -1): DIV = A, REM = 0.
- Flush_i high at an edge: state forced to IDLE, no Valid_o pulse for the aborted op. Flush_i has priority over completion in the same cycle. When Flush_i and Valid_i are both high in IDLE, the new op is dropped.
- Operands and decode are latched at accept; input changes while Busy_o = 1 are ignored.
- Valid_i while Ready_o = 0 is ignored; the requester must hold the request.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: full behaviour above.
- Undefined: MUL/DIV states and datapath are not built. R-type with Funct7 = 0000001 returns 0 with latency 1. Ready_o is tied to 1 and Busy_o to 0.

Test Plan:
- Reset, then R-type ADD with A = 5, B = 7 -> Valid_o in the next cycle, Result_o = 12. Follow next cycle with SUB 3-5 -> 0xFFFFFFFE on the following cycle.
- MULH with A = 0xFFFFFFFF (-1), B = 2 -> Busy_o high for 32 cycles, Valid_o at cycle 33 after accept, Result_o = 0xFFFFFFFF. MULHU with the same operands -> 0x00000001.
- DIV with A = 0x80000000, B = 0xFFFFFFFF -> Valid_o in the next cycle, Result_o = 0x80000000. REM with the same operands -> 0.
- DIVU with A = 100, B = 0 -> 0xFFFFFFFF in 1 cycle. REMU with A = 100, B = 0 -> 100.
- DIV with A = -7, B = 2 -> -3; REM with the same operands -> -1. Assert Flush_i at iteration 10 of a second DIV -> no Valid_o, Ready_o = 1 on the next cycle, Result_o still -1.
- Assert rst_i mid-MUL -> all outputs return to their reset values on the next cycle. Repeat with ALU_MULDIV_EN undefined: MUL -> 0 in 1 cycle and Busy_o never high.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: EX-stage integer ALU with iterative shift-add multiply and restoring divide.
// Define ALU_MULDIV_EN to build the MUL/DIV datapath; otherwise M-ext ops return 0 in one cycle.
module alu_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               Valid_i,
  output logic               Ready_o,
  input  logic [XLEN-1:0]    OperandA_i,
  input  logic [XLEN-1:0]    OperandB_i,
  input  logic [6:0]         Funct7_i,
  input  logic [2:0]         Funct3_i,
  input  logic [1:0]         ALUOp_i,
  input  logic               Flush_i,
  output logic               Valid_o,
  output logic [XLEN-1:0]    Result_o,
  output logic               Busy_o
);

  logic               r_type;
  logic               i_type;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sra_val;
  logic [XLEN-1:0]    srl_val;
  logic [XLEN-1:0]    base_result;
  logic               valid_reg;
  logic [XLEN-1:0]    result_reg;

  assign r_type  = (ALUOp_i == 2'b10);
  assign i_type  = (ALUOp_i == 2'b11);
  assign shamt   = OperandB_i[SHAMT_W-1:0];
  assign sra_val = $unsigned($signed(OperandA_i) >>> shamt);
  assign srl_val = OperandA_i >> shamt;

  assign Valid_o  = valid_reg;
  assign Result_o = result_reg;

  // Single-cycle ops; unknown R-type funct7 encodings fall through to 0.
  always_comb begin
    base_result = '0;
    if (ALUOp_i == 2'b00) begin
      base_result = OperandA_i + OperandB_i;
    end else if (ALUOp_i == 2'b01) begin
      base_result = OperandA_i - OperandB_i;
    end else if (i_type || (r_type && Funct7_i == 7'b0000000)) begin
      case (Funct3_i)
        3'b000:  base_result = OperandA_i + OperandB_i;
        3'b001:  base_result = OperandA_i << shamt;
        3'b010:  base_result = {{(XLEN-1){1'b0}}, $signed(OperandA_i) < $signed(OperandB_i)};
        3'b011:  base_result = {{(XLEN-1){1'b0}}, OperandA_i < OperandB_i};
        3'b100:  base_result = OperandA_i ^ OperandB_i;
        3'b101:  base_result = (i_type && Funct7_i[5]) ? sra_val : srl_val;
        3'b110:  base_result = OperandA_i | OperandB_i;
        default: base_result = OperandA_i & OperandB_i;
      endcase
    end else if (r_type && Funct7_i == 7'b0100000) begin
      if (Funct3_i == 3'b000)      base_result = OperandA_i - OperandB_i;
      else if (Funct3_i == 3'b101) base_result = sra_val;
    end
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [SHAMT_W-1:0] count_reg;
  logic [XLEN-1:0]    hi_reg;
  logic [XLEN-1:0]    lo_reg;
  logic [XLEN-1:0]    opnd_reg;
  logic [1:0]         op_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;

  logic               m_op, is_mul, div_signed, a_signed, b_signed;
  logic               a_neg, b_neg, div_zero, div_ovf, iter_start, last_step;
  logic [XLEN-1:0]    a_mag, b_mag, quick_result;
  logic [XLEN:0]      mul_sum;
  logic [XLEN-1:0]    mul_hi_next, mul_lo_next, mul_result;
  logic [2*XLEN-1:0]  prod, prod_fix;
  logic [XLEN:0]      div_shift, div_diff;
  logic               div_ge;
  logic [XLEN-1:0]    div_hi_next, div_lo_next, div_quo, div_rem, div_result;

  assign m_op       = r_type && (Funct7_i == 7'b0000001);
  assign is_mul     = !Funct3_i[2];
  assign div_signed = !Funct3_i[0];
  assign a_signed   = is_mul ? (Funct3_i[1:0] == 2'b01 || Funct3_i[1:0] == 2'b10) : div_signed;
  assign b_signed   = is_mul ? (Funct3_i[1:0] == 2'b01) : div_signed;
  assign a_neg      = a_signed && OperandA_i[XLEN-1];
  assign b_neg      = b_signed && OperandB_i[XLEN-1];
  assign a_mag      = a_neg ? -OperandA_i : OperandA_i;
  assign b_mag      = b_neg ? -OperandB_i : OperandB_i;
  assign div_zero   = (OperandB_i == '0);
  assign div_ovf    = div_signed && (OperandA_i == {1'b1, {(XLEN-1){1'b0}}}) && (OperandB_i == '1);
  assign iter_start = m_op && (is_mul || !(div_zero || div_ovf));
  assign last_step  = (count_reg == SHAMT_W'(XLEN-1));

  always_comb begin
    quick_result = base_result;
    if (m_op && !is_mul) begin
      if (div_zero)     quick_result = Funct3_i[1] ? OperandA_i : '1;
      else if (div_ovf) quick_result = Funct3_i[1] ? '0 : OperandA_i;
    end
  end

  // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
  assign prod        = {mul_hi_next, mul_lo_next};
  assign prod_fix    = neg_res_reg ? -prod : prod;
  assign mul_result  = (op_reg == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_shift   = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff    = div_shift - {1'b0, opnd_reg};
  assign div_ge      = !div_diff[XLEN];
  assign div_hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_next = {lo_reg[XLEN-2:0], div_ge};
  assign div_quo     = neg_res_reg ? -div_lo_next : div_lo_next;
  assign div_rem     = neg_rem_reg ? -div_hi_next : div_hi_next;
  assign div_result  = op_reg[1] ? div_rem : div_quo;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (Flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     if (Valid_i && iter_start) state_next = is_mul ? MUL : DIV;
        MUL, DIV: if (last_step) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    Ready_o = (state_reg == IDLE);
    Busy_o  = (state_reg != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg   <= 1'b0;
      result_reg  <= '0;
      count_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      op_reg      <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (Flush_i) begin
        count_reg <= '0;
      end else if (state_reg == IDLE) begin
        if (Valid_i) begin
          if (iter_start) begin
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= is_mul ? b_mag : a_mag;
            opnd_reg    <= is_mul ? a_mag : b_mag;
            op_reg      <= Funct3_i[1:0];
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
          end else begin
            result_reg <= quick_result;
            valid_reg  <= 1'b1;
          end
        end
      end else begin
        hi_reg    <= (state_reg == MUL) ? mul_hi_next : div_hi_next;
        lo_reg    <= (state_reg == MUL) ? mul_lo_next : div_lo_next;
        count_reg <= count_reg + SHAMT_W'(1);
        if (last_step) begin
          result_reg <= (state_reg == MUL) ? mul_result : div_result;
          valid_reg  <= 1'b1;
          count_reg  <= '0;
        end
      end
    end
  end
`else
  assign Ready_o = 1'b1;
  assign Busy_o  = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (Valid_i && !Flush_i) begin
        result_reg <= base_result;
        valid_reg  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit; expectations switch on ALU_MULDIV_EN.
module tb_alu_muldiv_unit;

`ifdef ALU_MULDIV_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int ITER_LAT = EN ? 33 : 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Valid_i;
  logic        Ready_o;
  logic [31:0] OperandA_i;
  logic [31:0] OperandB_i;
  logic [6:0]  Funct7_i;
  logic [2:0]  Funct3_i;
  logic [1:0]  ALUOp_i;
  logic        Flush_i;
  logic        Valid_o;
  logic [31:0] Result_o;
  logic        Busy_o;

  int errors = 0;
  int checks = 0;

  alu_muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .OperandA_i(OperandA_i), .OperandB_i(OperandB_i), .Funct7_i(Funct7_i),
    .Funct3_i(Funct3_i), .ALUOp_i(ALUOp_i), .Flush_i(Flush_i),
    .Valid_o(Valid_o), .Result_o(Result_o), .Busy_o(Busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    ALUOp_i = op; Funct7_i = f7; Funct3_i = f3; OperandA_i = a; OperandB_i = b; Valid_i = 1'b1;
  endtask

  task automatic base_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    drive(op, f7, f3, a, b);
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    check({tag, "_vld"}, {31'd0, Valid_o}, 32'd1);
    check({tag, "_res"}, Result_o, exp);
  endtask

  // Issue one op, scramble inputs after accept, and wait (bounded) for completion.
  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_n;
    drive(2'b10, f7, f3, a, b);
    @(posedge clk_i); #1;
    Valid_i = 1'b0; OperandA_i = 32'h5a5a5a5a; OperandB_i = 32'h3; Funct3_i = 3'b000;
    lat = 1; busy_n = 0;
    while (!Valid_o && lat < 100) begin
      if (Busy_o) busy_n++;
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, "_res"}, Result_o, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_n), 32'(exp_lat - 1));
  endtask

  task automatic idle_watch(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      if (Valid_o) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; Valid_i = 1'b0; Flush_i = 1'b0;
    OperandA_i = '0; OperandB_i = '0; Funct7_i = '0; Funct3_i = '0; ALUOp_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, Valid_o}, 32'd0);
    check("rst_result", Result_o, 32'd0);
    check("rst_ready", {31'd0, Ready_o}, 32'd1);
    check("rst_busy", {31'd0, Busy_o}, 32'd0);
    rst_i = 1'b0;

    // Back-to-back ADD then SUB, then the pulse must drop.
    drive(2'b10, 7'h00, 3'b000, 32'd5, 32'd7);
    @(posedge clk_i); #1;
    check("add_vld", {31'd0, Valid_o}, 32'd1);
    check("add_res", Result_o, 32'd12);
    drive(2'b10, 7'h20, 3'b000, 32'd3, 32'd5);
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    check("sub_vld", {31'd0, Valid_o}, 32'd1);
    check("sub_res", Result_o, 32'hFFFFFFFE);
    @(posedge clk_i); #1;
    check("pulse_drop", {31'd0, Valid_o}, 32'd0);
    check("res_hold", Result_o, 32'hFFFFFFFE);

    base_op("slt",      2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1);
    base_op("sltu",     2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0);
    base_op("srai",     2'b11, 7'h20, 3'b101, 32'h80000000, 32'd4,        32'hF8000000);
    base_op("srli",     2'b11, 7'h00, 3'b101, 32'h80000000, 32'd4,        32'h08000000);
    base_op("sll_mask", 2'b10, 7'h00, 3'b001, 32'd3,        32'd33,       32'd6);
    base_op("xor",      2'b10, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    base_op("ori",      2'b11, 7'h00, 3'b110, 32'h0000000F, 32'h000000F0, 32'h000000FF);
    base_op("and",      2'b10, 7'h00, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    base_op("sra",      2'b10, 7'h20, 3'b101, 32'h80000010, 32'd1,        32'hC0000008);
    base_op("aluop_sub",2'b01, 7'h00, 3'b111, 32'd10,       32'd3,        32'd7);
    base_op("aluop_add",2'b00, 7'h20, 3'b101, 32'd1,        32'd2,        32'd3);
    base_op("bad_f7",   2'b10, 7'h10, 3'b000, 32'd5,        32'd7,        32'd0);
    base_op("addi_f7",  2'b11, 7'h20, 3'b000, 32'd5,        32'd7,        32'd12);
    base_op("srl",      2'b10, 7'h00, 3'b101, 32'h80000000, 32'd31,       32'd1);

    // Flush together with a request in IDLE drops the request.
    drive(2'b10, 7'h00, 3'b000, 32'd9, 32'd9);
    Flush_i = 1'b1;
    @(posedge clk_i); #1;
    Valid_i = 1'b0; Flush_i = 1'b0;
    check("flush_drop_vld", {31'd0, Valid_o}, 32'd0);
    check("flush_drop_res", Result_o, 32'd1);
    idle_watch("flush_drop_late", 2);

    run_op("mulh",   7'h01, 3'b001, 32'hFFFFFFFF, 32'd2, EN ? 32'hFFFFFFFF : 32'd0, ITER_LAT);
    run_op("mulhu",  7'h01, 3'b011, 32'hFFFFFFFF, 32'd2, EN ? 32'h00000001 : 32'd0, ITER_LAT);
    run_op("mulhsu", 7'h01, 3'b010, 32'hFFFFFFFF, 32'd2, EN ? 32'hFFFFFFFF : 32'd0, ITER_LAT);
    run_op("mul",    7'h01, 3'b000, 32'hFFFFFFFD, 32'd5, EN ? 32'hFFFFFFF1 : 32'd0, ITER_LAT);
    run_op("div_ovf",7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, EN ? 32'h80000000 : 32'd0, 1);
    run_op("rem_ovf",7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_op("divu_z", 7'h01, 3'b101, 32'd100, 32'd0, EN ? 32'hFFFFFFFF : 32'd0, 1);
    run_op("remu_z", 7'h01, 3'b111, 32'd100, 32'd0, EN ? 32'd100 : 32'd0, 1);
    run_op("divu",   7'h01, 3'b101, 32'd100, 32'd7, EN ? 32'd14 : 32'd0, ITER_LAT);
    run_op("remu",   7'h01, 3'b111, 32'd100, 32'd7, EN ? 32'd2 : 32'd0, ITER_LAT);
    run_op("div_neg",7'h01, 3'b100, 32'hFFFFFFF9, 32'd2, EN ? 32'hFFFFFFFD : 32'd0, ITER_LAT);
    run_op("rem_neg",7'h01, 3'b110, 32'hFFFFFFF9, 32'd2, EN ? 32'hFFFFFFFF : 32'd0, ITER_LAT);

`ifdef ALU_MULDIV_EN
    // Flush in the middle of a divide: no completion, result unchanged.
    drive(2'b10, 7'h01, 3'b100, 32'hFFFFFFF9, 32'd2);
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    Flush_i = 1'b1;
    @(posedge clk_i); #1;
    Flush_i = 1'b0;
    check("flush_div_vld", {31'd0, Valid_o}, 32'd0);
    check("flush_div_rdy", {31'd0, Ready_o}, 32'd1);
    check("flush_div_res", Result_o, 32'hFFFFFFFF);
    idle_watch("flush_div_late", 40);
`endif

    base_op("pre_rst", 2'b10, 7'h00, 3'b000, 32'd1, 32'd1, 32'd2);
`ifdef ALU_MULDIV_EN
    drive(2'b10, 7'h01, 3'b000, 32'd6, 32'd7);
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("mid_mul_busy", {31'd0, Busy_o}, 32'd1);
`endif
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst2_valid", {31'd0, Valid_o}, 32'd0);
    check("rst2_result", Result_o, 32'd0);
    check("rst2_ready", {31'd0, Ready_o}, 32'd1);
    check("rst2_busy", {31'd0, Busy_o}, 32'd0);
    idle_watch("rst2_late", 40);
    check("rst2_result_hold", Result_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
